fir_serial_sym: RTL and testbench

Parametrised successor to the fixed 16-tap serial FIR. It is a symmetric-coefficient, time-multiplexed FIR filter for signed two's-complement samples. Each accepted sample is folded into TAPS/2 pre-add pairs and processed through one pre-adder and one multiplier over TAPS/2 system-clock cycles. It sits between the sample source, which has a valid/ready handshake, and downstream decimation/output logic, and runs at a system clock at least TAPS/2 times the sample rate.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_mac_fold.sv | 88 ++++++++
 rtl/fir_serial_sym.sv | 170 +++++++++++++++++
 tb/tb_fir_serial_sym.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, width helpers and default coefficients for the folded serial FIR.
package fir_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fir_state_t;

  localparam int FIR_DEF_COEF_W = 12;

  // Entry k of the folded set lives in bits [k*COEF_W +: COEF_W].
  localparam logic [8*FIR_DEF_COEF_W-1:0] FIR_DEF_COEF_INIT = {
    12'd255, 12'd235, 12'd198, 12'd152, 12'd104, 12'd63, 12'd31, 12'd11
  };

  function automatic int fir_pa_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int fir_prod_w(input int data_w, input int coef_w);
    return fir_pa_w(data_w) + coef_w;
  endfunction

  function automatic int fir_out_w(input int data_w, input int coef_w, input int m);
    return fir_prod_w(data_w, coef_w) + $clog2(m);
  endfunction

endpackage

// File: rtl/fir_mac_fold.sv
// Pre-add / multiply / accumulate pipeline of the folded FIR (operand stage to accumulator).
module fir_mac_fold
  import fir_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int M      = 8,
  localparam int PA_W   = fir_pa_w(DATA_W),
  localparam int PROD_W = fir_prod_w(DATA_W, COEF_W),
  localparam int OUT_W  = fir_out_w(DATA_W, COEF_W, M)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  input  logic                     first,
  input  logic                     last,
  input  logic                     warm,
  input  logic signed [DATA_W-1:0] xa,
  input  logic signed [DATA_W-1:0] xb,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [OUT_W-1:0]  acc,
  output logic                     done
);

  logic signed [PA_W-1:0]   pa_r;
  logic signed [COEF_W-1:0] c_r;
  logic                     a_vld_r, a_first_r, a_last_r, a_warm_r;
  logic signed [PROD_W-1:0] prod_r;
  logic                     b_vld_r, b_first_r, b_last_r, b_warm_r;
  logic signed [OUT_W-1:0]  acc_r;
  logic signed [OUT_W-1:0]  prod_ext_s;
  logic                     done_r;

  assign prod_ext_s = {{(OUT_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};

  // Stage A: fold the mirrored taps and latch the matching coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_r      <= '0;
      c_r       <= '0;
      a_vld_r   <= 1'b0;
      a_first_r <= 1'b0;
      a_last_r  <= 1'b0;
      a_warm_r  <= 1'b0;
    end else begin
      pa_r      <= {xa[DATA_W-1], xa} + {xb[DATA_W-1], xb};
      c_r       <= coef;
      a_vld_r   <= issue;
      a_first_r <= first;
      a_last_r  <= last;
      a_warm_r  <= warm;
    end
  end

  // Stage B: signed product at full width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r    <= '0;
      b_vld_r   <= 1'b0;
      b_first_r <= 1'b0;
      b_last_r  <= 1'b0;
      b_warm_r  <= 1'b0;
    end else begin
      prod_r    <= PROD_W'(pa_r) * PROD_W'(c_r);
      b_vld_r   <= a_vld_r;
      b_first_r <= a_first_r;
      b_last_r  <= a_last_r;
      b_warm_r  <= a_warm_r;
    end
  end

  // Stage C: first product of a sample loads, later ones add; done marks a complete warm result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= '0;
      done_r <= 1'b0;
    end else begin
      if (b_vld_r) begin
        acc_r <= b_first_r ? prod_ext_s : (acc_r + prod_ext_s);
      end
      done_r <= b_vld_r & b_last_r & b_warm_r;
    end
  end

  assign acc  = acc_r;
  assign done = done_r;

endmodule

// File: rtl/fir_serial_sym.sv
// Symmetric time-multiplexed FIR: FSM, delay line and coefficient source around fir_mac_fold.
// Optional runtime coefficient writes are enabled by defining FIR_SERIAL_SYM_COEF_WR_EN.
module fir_serial_sym
  import fir_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = FIR_DEF_COEF_W,
  parameter int TAPS   = 16,
  parameter logic [(TAPS/2)*COEF_W-1:0] COEF_INIT = FIR_DEF_COEF_INIT,
  localparam int M     = TAPS / 2,
  localparam int CNT_W = $clog2(M),
  localparam int OUT_W = fir_out_w(DATA_W, COEF_W, M)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
`ifdef FIR_SERIAL_SYM_COEF_WR_EN
  input  logic                     coef_we,
  input  logic [CNT_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_busy,
`endif
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data
);

  localparam int TAP_W  = $clog2(TAPS);
  localparam int SCNT_W = $clog2(TAPS + 1);

  fir_state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]         cnt_r, cnt_nx_s;
  logic                     in_ready_r, ready_nx_s, accept_s, issue_s;
  logic signed [DATA_W-1:0] x_r [TAPS];
  logic [SCNT_W-1:0]        smp_cnt_r;
  logic                     smp_warm_r;
  logic [TAP_W-1:0]         idx_lo_s, idx_hi_s;
  logic signed [COEF_W-1:0] coef_sel_s;
  logic                     mac_done_s;
  logic signed [OUT_W-1:0]  mac_acc_s;
  logic                     out_valid_r;
  logic signed [OUT_W-1:0]  out_data_r;

  assign accept_s = in_valid & in_ready_r;

  // Next state: one folded pair per cycle, a new sample only on the last pair or from IDLE.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    issue_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = RUN;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          state_nx_s = IDLE;
          cnt_nx_s   = cnt_r;
        end
      end
      RUN: begin
        issue_s = 1'b1;
        if (cnt_r == CNT_W'(M - 1)) begin
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = accept_s ? RUN : IDLE;
        end else begin
          cnt_nx_s   = cnt_r + CNT_W'(1);
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
    ready_nx_s = (state_nx_s == IDLE) || (cnt_nx_s == CNT_W'(M - 1));
  end

  // State, pair counter and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      in_ready_r <= ready_nx_s;
    end
  end

  // Delay line and saturating warm-up count; warmth is tagged to each sample at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x_r[i] <= '0;
      smp_cnt_r  <= {SCNT_W{1'b0}};
      smp_warm_r <= 1'b0;
    end else if (accept_s) begin
      x_r[0] <= in_data;
      for (int i = 1; i < TAPS; i++) x_r[i] <= x_r[i-1];
      smp_warm_r <= (smp_cnt_r >= SCNT_W'(TAPS - 1));
      if (smp_cnt_r != SCNT_W'(TAPS)) smp_cnt_r <= smp_cnt_r + SCNT_W'(1);
    end
  end

`ifdef FIR_SERIAL_SYM_COEF_WR_EN
  logic signed [COEF_W-1:0] coef_r [M];
  logic                     coef_busy_r;

  // Coefficient file: writes only land while idle so a running sample sees a stable set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < M; k++) coef_r[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      coef_busy_r <= 1'b0;
    end else begin
      if (coef_we && (state_r == IDLE)) coef_r[coef_addr] <= coef_wdata;
      coef_busy_r <= (state_nx_s != IDLE);
    end
  end

  assign coef_sel_s = coef_r[cnt_r];
  assign coef_busy  = coef_busy_r;
`else
  logic signed [COEF_W-1:0] coef_s [M];

  for (genvar k = 0; k < M; k++) begin : g_coef
    assign coef_s[k] = COEF_INIT[k*COEF_W +: COEF_W];
  end

  assign coef_sel_s = coef_s[cnt_r];
`endif

  assign idx_lo_s = TAP_W'(cnt_r);
  assign idx_hi_s = TAP_W'(TAPS - 1) - TAP_W'(cnt_r);

  fir_mac_fold #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .M      (M)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .issue (issue_s),
    .first (cnt_r == {CNT_W{1'b0}}),
    .last  (cnt_r == CNT_W'(M - 1)),
    .warm  (smp_warm_r),
    .xa    (x_r[idx_lo_s]),
    .xb    (x_r[idx_hi_s]),
    .coef  (coef_sel_s),
    .acc   (mac_acc_s),
    .done  (mac_done_s)
  );

  // Output capture: data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= mac_done_s;
      if (mac_done_s) out_data_r <= mac_acc_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fir_serial_sym.sv
// Randomised bench for fir_serial_sym against a direct-form convolution model,
// plus a small TAPS=4 instance driven with an impulse.
module tb_fir_serial_sym;

  localparam int DATA_W  = 12;
  localparam int TAPS    = 16;
  localparam int M       = 8;
  localparam int OUT_W   = 28;
  localparam int LAT     = M + 3;
  localparam int S_TAPS  = 4;
  localparam int S_M     = 2;
  localparam int S_OUT_W = 18;
  localparam int S_LAT   = S_M + 3;

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     in_valid, in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [11:0]       coef_wdata;
  logic                     coef_busy;

  logic                     in_valid2, in_ready2;
  logic signed [7:0]        in_data2;
  logic                     out_valid2;
  logic signed [S_OUT_W-1:0] out_data2;
  logic                     coef_we2;
  logic [0:0]               coef_addr2;
  logic signed [7:0]        coef_wdata2;
  logic                     coef_busy2;

  fir_serial_sym dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef FIR_SERIAL_SYM_COEF_WR_EN
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_busy  (coef_busy),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  fir_serial_sym #(
    .DATA_W    (8),
    .COEF_W    (8),
    .TAPS      (S_TAPS),
    .COEF_INIT (16'h64F9)
  ) dut_small (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_data    (in_data2),
`ifdef FIR_SERIAL_SYM_COEF_WR_EN
    .coef_we    (coef_we2),
    .coef_addr  (coef_addr2),
    .coef_wdata (coef_wdata2),
    .coef_busy  (coef_busy2),
`endif
    .out_valid  (out_valid2),
    .out_data   (out_data2)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  int     init_h [M] = '{11, 31, 63, 104, 152, 198, 235, 255};
  int     h_m    [M];
  int     hist_q [$];
  exp_t   exp_q  [$];
  int     n_acc    = 0;
  bit     bp_mode  = 1'b0;
  longint bp_last  = -1;

  int     small_tab [6] = '{-7, 100, 100, -7, 0, 0};
  exp_t   exp2_q [$];
  int     n_acc2 = 0;
  int     n_out2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic int h_of(input int i);
    return h_m[(i < M) ? i : (TAPS - 1 - i)];
  endfunction

  // Reference: plain convolution over the last TAPS accepted samples.
  initial begin
    exp_t   e;
    longint y;
    forever begin
      @(negedge clk);
      if (rst) begin
        hist_q.delete();
        exp_q.delete();
        n_acc = 0;
      end else begin
        if (out_valid) begin
          check("pulse_expected", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.val);
            check("latency", cyc, e.cyc);
          end
        end
        if (in_valid && in_ready) begin
          if (bp_mode) begin
            if (bp_last >= 0) check("accept_interval", cyc - bp_last, M);
            bp_last = cyc;
          end
          hist_q.push_front(int'(in_data));
          if (hist_q.size() > TAPS) void'(hist_q.pop_back());
          n_acc++;
          if (n_acc >= TAPS) begin
            y = 0;
            for (int i = 0; i < TAPS; i++) y += longint'(h_of(i)) * longint'(hist_q[i]);
            e.val = y;
            e.cyc = cyc + 1 + LAT;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // Small instance: impulse response is the mirrored coefficient set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp2_q.delete();
        n_acc2 = 0;
      end else begin
        if (out_valid2) begin
          n_out2++;
          check("s_pulse_expected", longint'(exp2_q.size() > 0), 1);
          if (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            check("s_out_data", out_data2, e.val);
            check("s_latency", cyc, e.cyc);
          end
        end
        if (in_valid2 && in_ready2) begin
          n_acc2++;
          if (n_acc2 >= S_TAPS && (n_acc2 - S_TAPS) < 6) begin
            e.val = small_tab[n_acc2 - S_TAPS];
            e.cyc = cyc + 1 + S_LAT;
            exp2_q.push_back(e);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [DATA_W-1:0] d, input bit hold);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 4 * M) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("ready_wait", longint'(t < 4 * M), 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic send2(input logic signed [7:0] d);
    int t = 0;
    in_data2  = d;
    in_valid2 = 1'b1;
    while (!in_ready2 && t < 16) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("s_ready_wait", longint'(t < 16), 1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  task automatic impulse();
    for (int i = 0; i < 33; i++) send((i == 15) ? 12'sd1 : 12'sd0, 1'b0);
    idle(LAT + 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
`ifdef FIR_SERIAL_SYM_COEF_WR_EN
    check({tag, "_coef_busy"}, coef_busy, 0);
`endif
  endtask

`ifdef FIR_SERIAL_SYM_COEF_WR_EN
  task automatic write_coef(input int addr, input int val, input bit exp_busy);
    check("coef_busy", coef_busy, exp_busy);
    coef_addr  = 3'(addr);
    coef_wdata = 12'(val);
    coef_we    = 1'b1;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (!exp_busy) h_m[addr] = val;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;   in_data = '0;
    in_valid2 = 1'b0;  in_data2 = '0;
    coef_we = 1'b0;    coef_addr = '0;  coef_wdata = '0;
    coef_we2 = 1'b0;   coef_addr2 = '0; coef_wdata2 = '0;
    for (int i = 0; i < M; i++) h_m[i] = init_h[i];
    idle(3);
    check_reset_outputs("rst");
    check("s_rst_in_ready", in_ready2, 1);
    check("s_rst_out_valid", out_valid2, 0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 9; i++) send2((i == 3) ? 8'sd1 : 8'sd0);
    idle(S_LAT + 4);

    impulse();

    for (int i = 0; i < 24; i++) send(12'h800, 1'b0);
    for (int i = 0; i < 24; i++) send(12'h7FF, 1'b0);
    idle(LAT + 4);

    for (int i = 0; i < 40; i++) begin
      send(DATA_W'($urandom), 1'b0);
      idle($urandom_range(0, 10));
    end
    idle(LAT + 4);

    bp_mode = 1'b1;
    bp_last = -1;
    for (int i = 0; i < 30; i++) send(DATA_W'($urandom), 1'b1);
    in_valid = 1'b0;
    bp_mode  = 1'b0;
    idle(LAT + 4);

`ifdef FIR_SERIAL_SYM_COEF_WR_EN
    write_coef(7, -1, 1'b0);
    send(12'sd0, 1'b0);
    write_coef(3, 0, 1'b1);
    idle(LAT + 4);
    impulse();
`endif

    send(12'sd100, 1'b0);
    idle(3);
    rst = 1'b1;
    for (int i = 0; i < M; i++) h_m[i] = init_h[i];
    #1;
    check_reset_outputs("midrun");
    idle(2);
    rst = 1'b0;
    idle(LAT + 4);
    for (int i = 0; i < 15; i++) send(DATA_W'($urandom_range(1, 2047)), 1'b0);
    idle(LAT + 4);
    check("warmup_hold", out_data, 0);
    impulse();

    idle(LAT + 4);
    check("exp_drained", exp_q.size(), 0);
    check("s_exp_drained", exp2_q.size(), 0);
    check("s_outputs", n_out2, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
